// File: rtl/uart_regfile_pkg.sv
// Shared constants, lock state encoding and reset defaults for the UART-facing register file.
package uart_regfile_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] ADDR_CHIP_ID   = 8'hF0;
  localparam logic [DATA_W-1:0] ADDR_STATUS    = 8'hF1;
  localparam logic [DATA_W-1:0] ADDR_EVENT     = 8'hF2;
  localparam logic [DATA_W-1:0] ADDR_IRQ_MASK  = 8'hF3;
  localparam logic [DATA_W-1:0] ADDR_LOCK      = 8'hF4;
  localparam logic [DATA_W-1:0] ADDR_ERR_COUNT = 8'hF6;

  // Byte written to the LOCK register to enter the locked state
  localparam logic [DATA_W-1:0] LOCK_CMD = 8'h01;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_LOCKED   = 2'd1,
    LOCK_ARMED    = 2'd2
  } lock_state_e;

  function automatic logic [DATA_W-1:0] cfg_default(input int unsigned idx);
    return (idx == 0) ? 8'h01 : 8'h00;
  endfunction

endpackage

// File: rtl/uart_regfile_lock.sv
// Keyed write-lock state machine: LOCK_CMD locks, LOCK_KEY then ~LOCK_KEY unlocks.
module uart_regfile_lock
  import uart_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_acc,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] lock_key,
  output logic              locked
);

  lock_state_e state_q, state_d;
  logic        locked_q, locked_d;
  logic        is_lock_wr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= LOCK_UNLOCKED;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_lock_wr = wr_acc && (wr_addr == ADDR_LOCK);
    unique case (state_q)
      LOCK_UNLOCKED: if (is_lock_wr && (wr_data == LOCK_CMD)) state_d = LOCK_LOCKED;
      LOCK_LOCKED:   if (is_lock_wr && (wr_data == lock_key)) state_d = LOCK_ARMED;
      // Armed only survives one write: the unlock byte or fall back to locked
      LOCK_ARMED:    if (wr_acc) state_d = (is_lock_wr && (wr_data == ~lock_key)) ? LOCK_UNLOCKED
                                                                                   : LOCK_LOCKED;
      default:       state_d = LOCK_UNLOCKED;
    endcase
    locked_d = (state_d != LOCK_UNLOCKED);
  end

  assign locked = locked_q;

endmodule

// File: rtl/uart_regfile.sv
// Register file behind the UART controller: config regs, ID/status, W1C events with irq,
// write lock and a saturating error counter.
module uart_regfile
  import uart_regfile_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 64,
  parameter logic [DATA_W-1:0] CHIP_ID  = 8'h5A,
  parameter logic [DATA_W-1:0] LOCK_KEY = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       write,
  input  logic [DATA_W-1:0]          write_addr,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       read,
  input  logic [DATA_W-1:0]          read_addr,
  input  logic [DATA_W-1:0]          status_in,
  input  logic [DATA_W-1:0]          event_in,
  output logic [DATA_W-1:0]          read_data,
  output logic [NUM_REGS*DATA_W-1:0] config_bits,
  output logic                       irq,
  output logic                       locked
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              write_q;
  logic [DATA_W-1:0] cfg_q [NUM_REGS];
  logic [DATA_W-1:0] cfg_d [NUM_REGS];
  logic [DATA_W-1:0] event_q, event_d;
  logic [DATA_W-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_W-1:0] err_count_q, err_count_d;
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              irq_q, irq_d;

  logic              wr_acc;
  logic              wr_is_cfg, rd_is_cfg;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] ev_clr;
  logic              err_now, err_clr;
  logic [DATA_W-1:0] rd_val;

  // A held strobe is one transaction: only its rising cycle is accepted
  assign wr_acc    = write && !write_q;
  assign wr_is_cfg = write_addr < DATA_W'(NUM_REGS);
  assign rd_is_cfg = read_addr < DATA_W'(NUM_REGS);
  assign wr_idx    = write_addr[IDX_W-1:0];
  assign rd_idx    = read_addr[IDX_W-1:0];

  uart_regfile_lock u_lock (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_acc   (wr_acc),
    .wr_addr  (write_addr),
    .wr_data  (write_data),
    .lock_key (LOCK_KEY),
    .locked   (locked)
  );

  // Write decode, event flags, error counting and interrupt
  always_comb begin
    cfg_d      = cfg_q;
    irq_mask_d = irq_mask_q;
    ev_clr     = '0;
    err_now    = 1'b0;
    err_clr    = 1'b0;
    if (wr_acc) begin
      if (wr_is_cfg) begin
        if (locked) err_now = 1'b1;
        else        cfg_d[wr_idx] = write_data;
      end else begin
        case (write_addr)
          ADDR_CHIP_ID, ADDR_STATUS: err_now = 1'b1;
          ADDR_EVENT:                ev_clr = write_data;
          ADDR_IRQ_MASK:             irq_mask_d = write_data;
          ADDR_LOCK:                 begin end
          ADDR_ERR_COUNT:            err_clr = 1'b1;
          default:                   err_now = 1'b1;
        endcase
      end
    end
    // A new event beats a simultaneous clear
    event_d = (event_q & ~ev_clr) | event_in;
    if (err_clr)                              err_count_d = '0;
    else if (err_now && (err_count_q != '1))  err_count_d = err_count_q + DATA_W'(1);
    else                                      err_count_d = err_count_q;
    irq_d = |(event_d & irq_mask_q);
  end

  // Read mux samples pre-write state so same-cycle read/write returns the old value
  always_comb begin
    rd_val = '0;
    if (rd_is_cfg) begin
      rd_val = cfg_q[rd_idx];
    end else begin
      case (read_addr)
        ADDR_CHIP_ID:   rd_val = CHIP_ID;
        ADDR_STATUS:    rd_val = status_q;
        ADDR_EVENT:     rd_val = event_q;
        ADDR_IRQ_MASK:  rd_val = irq_mask_q;
        ADDR_LOCK:      rd_val = {7'b0, locked};
        ADDR_ERR_COUNT: rd_val = err_count_q;
        default:        rd_val = '0;
      endcase
    end
    read_data_d = read ? rd_val : read_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_q     <= 1'b0;
      event_q     <= '0;
      irq_mask_q  <= '0;
      err_count_q <= '0;
      status_q    <= '0;
      read_data_q <= '0;
      irq_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) cfg_q[i] <= cfg_default(i);
    end else begin
      write_q     <= write;
      event_q     <= event_d;
      irq_mask_q  <= irq_mask_d;
      err_count_q <= err_count_d;
      status_q    <= status_in;
      read_data_q <= read_data_d;
      irq_q       <= irq_d;
      cfg_q       <= cfg_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
    assign config_bits[DATA_W*g +: DATA_W] = cfg_q[g];
  end

  assign read_data = read_data_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_regfile.sv
// Directed bench for uart_regfile with a rule-level reference model checked every cycle.
module tb_uart_regfile;

  localparam int unsigned NR = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] write_addr = '0, write_data = '0, read_addr = '0;
  logic [7:0] status_in = '0, event_in = '0;

  wire [7:0]      read_data;
  wire [NR*8-1:0] config_bits;
  wire            irq, locked;

  always #5 clk = ~clk;

  uart_regfile #(.NUM_REGS(NR), .CHIP_ID(8'h5A), .LOCK_KEY(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .write_addr(write_addr),
    .write_data(write_data), .read(read), .read_addr(read_addr),
    .status_in(status_in), .event_in(event_in), .read_data(read_data),
    .config_bits(config_bits), .irq(irq), .locked(locked)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%02h expected=%02h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain arrays, lock as a locked/armed flag pair
  logic [7:0] m_cfg [NR];
  logic [7:0] m_ev, m_mask, m_err, m_status, m_rd, m_clr, m_old_mask;
  logic       m_irq, m_locked, m_armed, m_wprev, m_acc;
  logic       m_valid = 1'b0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < 8'(NR)) return m_cfg[a[5:0]];
    case (a)
      8'hF0:   return 8'h5A;
      8'hF1:   return m_status;
      8'hF2:   return m_ev;
      8'hF3:   return m_mask;
      8'hF4:   return {7'b0, m_locked};
      8'hF6:   return m_err;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_error();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NR); i++) m_cfg[i] = (i == 0) ? 8'h01 : 8'h00;
      m_ev = 0; m_mask = 0; m_err = 0; m_status = 0; m_rd = 0;
      m_irq = 0; m_locked = 0; m_armed = 0;
      m_valid = 1'b1;
    end else begin
      if (read) m_rd = m_read(read_addr);
      m_old_mask = m_mask;
      m_acc = write && !m_wprev;
      m_clr = 0;
      if (m_acc) begin
        if (write_addr < 8'(NR)) begin
          if (m_locked) m_error();
          else m_cfg[write_addr[5:0]] = write_data;
        end else begin
          case (write_addr)
            8'hF0, 8'hF1: m_error();
            8'hF2: m_clr = write_data;
            8'hF3: m_mask = write_data;
            8'hF4: ;
            8'hF6: m_err = 0;
            default: m_error();
          endcase
        end
        if (m_armed) begin
          m_armed  = 0;
          m_locked = !(write_addr == 8'hF4 && write_data == 8'h5A);
        end else if (m_locked) begin
          if (write_addr == 8'hF4 && write_data == 8'hA5) m_armed = 1;
        end else if (write_addr == 8'hF4 && write_data == 8'h01) begin
          m_locked = 1;
        end
      end
      m_ev = (m_ev & ~m_clr) | event_in;
      m_irq = |(m_ev & m_old_mask);
      m_status = status_in;
    end
    m_wprev = reset_n ? write : 1'b0;
  end

  int bad_i;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("read_data", read_data, m_rd);
      chk("irq", {7'b0, irq}, {7'b0, m_irq});
      chk("locked", {7'b0, locked}, {7'b0, m_locked});
      bad_i = -1;
      for (int i = 0; i < int'(NR); i++)
        if (bad_i < 0 && config_bits[8*i +: 8] !== m_cfg[i]) bad_i = i;
      n_vec++;
      if (bad_i >= 0) begin
        n_bad++;
        $display("FAIL config_bits reg%0d got=%02h expected=%02h at %0t",
                 bad_i, config_bits[8*bad_i +: 8], m_cfg[bad_i], $time);
      end
    end
  end

  // Drivers: called at a falling edge, return at a falling edge
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold = 1);
    write = 1'b1; write_addr = a; write_data = d;
    repeat (hold) @(negedge clk);
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    read = 1'b1; read_addr = a;
    @(negedge clk);
    read = 1'b0;
    v = read_data;
  endtask

  logic [7:0] v;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_read_data", read_data, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_locked", {7'b0, locked}, 8'h00);
    chk("rst_cfg0", config_bits[7:0], 8'h01);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset-state reads
    rd(8'h00, v); chk("t1_rd_00", v, 8'h01);
    rd(8'hF0, v); chk("t1_rd_f0", v, 8'h5A);
    rd(8'h7F, v); chk("t1_rd_7f", v, 8'h00);

    // Held strobes count once
    wr(8'h05, 8'h3C, 2);
    chk("t2_cfg5", config_bits[47:40], 8'h3C);
    wr(8'hF2, 8'h01, 2);
    rd(8'hF6, v); chk("t2_err", v, 8'h00);
    status_in = 8'hC3;
    @(negedge clk);
    rd(8'hF1, v); chk("t2_status", v, 8'hC3);

    // Lock, blocked write, unlock sequence
    wr(8'hF4, 8'h01);
    chk("t3_locked", {7'b0, locked}, 8'h01);
    wr(8'h05, 8'h77);
    chk("t3_cfg5_kept", config_bits[47:40], 8'h3C);
    rd(8'hF6, v); chk("t3_err1", v, 8'h01);
    wr(8'hF4, 8'hA5);
    chk("t3_armed_locked", {7'b0, locked}, 8'h01);
    wr(8'hF4, 8'h5A);
    chk("t3_unlocked", {7'b0, locked}, 8'h00);
    wr(8'h05, 8'h77);
    chk("t3_cfg5_new", config_bits[47:40], 8'h77);
    rd(8'hF4, v); chk("t3_rd_lock", v, 8'h00);

    // Armed sequence broken by an intervening write
    wr(8'h10, 8'hEE);
    wr(8'hF4, 8'h01);
    wr(8'hF4, 8'hA5);
    wr(8'h10, 8'h00);
    wr(8'hF4, 8'h5A);
    chk("t4_still_locked", {7'b0, locked}, 8'h01);
    chk("t4_cfg10", config_bits[135:128], 8'hEE);
    rd(8'hF6, v); chk("t4_err2", v, 8'h02);
    rd(8'hF4, v); chk("t4_rd_lock", v, 8'h01);
    wr(8'hF4, 8'hA5);
    wr(8'hF4, 8'h5A);
    chk("t4_unlocked", {7'b0, locked}, 8'h00);

    // Events, W1C with set priority, interrupt
    wr(8'hF3, 8'h04);
    event_in = 8'h04;
    @(negedge clk);
    event_in = 8'h00;
    chk("t5_irq_set", {7'b0, irq}, 8'h01);
    rd(8'hF2, v); chk("t5_event", v, 8'h04);
    write = 1'b1; write_addr = 8'hF2; write_data = 8'h04; event_in = 8'h04;
    @(negedge clk);
    write = 1'b0; event_in = 8'h00;
    chk("t5_irq_race", {7'b0, irq}, 8'h01);
    @(negedge clk);
    rd(8'hF2, v); chk("t5_event_race", v, 8'h04);
    wr(8'hF2, 8'h04);
    chk("t5_irq_clr", {7'b0, irq}, 8'h00);
    event_in = 8'h10;
    @(negedge clk);
    event_in = 8'h00;
    chk("t5_irq_masked", {7'b0, irq}, 8'h00);
    rd(8'hF2, v); chk("t5_event_unmasked", v, 8'h10);

    // Error counter saturation and clear
    for (int i = 0; i < 300; i++) wr(8'hF0, 8'(i));
    rd(8'hF6, v); chk("t6_err_sat", v, 8'hFF);
    wr(8'hF5, 8'h00);
    rd(8'hF6, v); chk("t6_err_hold", v, 8'hFF);
    wr(8'hF6, 8'h33);
    rd(8'hF6, v); chk("t6_err_clr", v, 8'h00);

    // Reset in the middle of a transaction
    wr(8'hF4, 8'h01);
    event_in = 8'h04;
    @(negedge clk);
    event_in = 8'h00;
    rd(8'hF0, v); chk("t6_pre_rst_rd", v, 8'h5A);
    chk("t6_pre_rst_irq", {7'b0, irq}, 8'h01);
    write = 1'b1; write_addr = 8'h00; write_data = 8'h99; reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_read_data", read_data, 8'h00);
    chk("t6_rst_irq", {7'b0, irq}, 8'h00);
    chk("t6_rst_locked", {7'b0, locked}, 8'h00);
    chk("t6_rst_cfg0", config_bits[7:0], 8'h01);
    chk("t6_rst_cfg5", config_bits[47:40], 8'h00);
    write = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    rd(8'hF3, v); chk("t6_rst_mask", v, 8'h00);
    rd(8'hF2, v); chk("t6_rst_event", v, 8'h00);
    rd(8'h10, v); chk("t6_rst_cfg10", v, 8'h00);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
